button_conditioner: RTL and testbench

- Conditions one raw, active-low push-button (BT[n]) for the timer controls; one instance per button.
- Performs 2-FF synchronisation, counter-based debounce and press/release edge pulses.
- Adds auto-repeat on hold, so a held ADD_SEC/ADD_MIN key steps the counters continuously.
- Sits directly upstream of the timer top and replaces the bare debouncer. LEVEL_N keeps the existing "0 while pressed" convention.

---
 rtl/button_conditioner.sv | 121 ++++++++++++
 tb/tb_button_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronised, debounced push-button with press/release pulses and auto-repeat
module button_conditioner #(
    parameter int DEB_CYCLES   = 250000,
    parameter int DELAY_CYCLES = 12587500,
    parameter int RATE_CYCLES  = 2517500
) (
    input  logic MCLK,
    input  logic RST_N,
    input  logic BT_N,
    input  logic REPEAT_EN,
    output logic LEVEL_N,
    output logic PRESS,
    output logic RELEASE,
    output logic REPEAT,
    output logic STROBE
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEATING} state_t;

    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_q, deb_d;
    logic          level_q, level_d;
    logic [RW-1:0] cnt_q, cnt_d, cnt_inc;
    state_t        state_q, state_d;
    logic          press_q, press_d, release_q, release_d, repeat_q, repeat_d, strobe_q;
    logic          accept, press_ev, release_ev;

    // two-flop synchroniser, idles at the released level
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= BT_N;
            sync2_q <= sync1_q;
        end
    end

    // debounce: count consecutive differing samples, adopt the new level on the terminal count
    always_comb begin
        accept     = (sync2_q != level_q) && (deb_q == DW'(DEB_CYCLES - 1));
        deb_d      = (sync2_q == level_q || accept) ? '0 : deb_q + 1'b1;
        level_d    = accept ? sync2_q : level_q;
        press_ev   = accept && !sync2_q;
        release_ev = accept && sync2_q;
    end

    // repeat FSM next state and pulse generation; release overrides any repeat terminal count
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + 1'b1;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        if (release_ev) begin
            release_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: if (press_ev) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = DELAY;
                end
                DELAY: if (!REPEAT_EN) begin
                    cnt_d = '0;
                end else if (cnt_inc == RW'(DELAY_CYCLES)) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = REPEATING;
                end else begin
                    cnt_d = cnt_inc;
                end
                REPEATING: if (!REPEAT_EN) begin
                    cnt_d   = '0;
                    state_d = DELAY;
                end else if (cnt_inc == RW'(RATE_CYCLES)) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state, counters and registered output pulses
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_q     <= '0;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            strobe_q  <= press_d | repeat_d;
        end
    end

    assign LEVEL_N = level_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;
    assign REPEAT  = repeat_q;
    assign STROBE  = strobe_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios for the button conditioner with small timing parameters
module tb_button_conditioner;
    logic MCLK = 1'b0;
    logic RST_N = 1'b0;
    logic BT_N = 1'b1;
    logic REPEAT_EN = 1'b0;
    logic LEVEL_N, PRESS, RELEASE, REPEAT, STROBE;

    int checks = 0;
    int errors = 0;
    int cyc, np, nr, nstb, nboth, p_at, r_at;
    int rep_at[$];

    button_conditioner #(.DEB_CYCLES(4), .DELAY_CYCLES(20), .RATE_CYCLES(5)) dut (
        .MCLK(MCLK), .RST_N(RST_N), .BT_N(BT_N), .REPEAT_EN(REPEAT_EN),
        .LEVEL_N(LEVEL_N), .PRESS(PRESS), .RELEASE(RELEASE), .REPEAT(REPEAT), .STROBE(STROBE)
    );

    always #5 MCLK = ~MCLK;

    task automatic clr();
        cyc = 0; np = 0; nr = 0; nstb = 0; nboth = 0; p_at = -1; r_at = -1;
        rep_at.delete();
    endtask

    // one clock; outputs sampled 1 time unit after the edge and logged with the cycle index
    task automatic tick();
        @(posedge MCLK);
        #1;
        cyc++;
        if (PRESS) begin np++; if (p_at < 0) p_at = cyc; end
        if (RELEASE) begin nr++; if (r_at < 0) r_at = cyc; end
        if (REPEAT) rep_at.push_back(cyc);
        if (STROBE) nstb++;
        if (PRESS && REPEAT) nboth++;
    endtask

    task automatic settle();
        BT_N = 1'b1;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0; BT_N = 1'b1; REPEAT_EN = 1'b1;
        repeat (3) @(posedge MCLK);
        #1;
        checks++; if (LEVEL_N !== 1'b1) begin errors++; $display("FAIL rst_level: got %b expected 1", LEVEL_N); end
        checks++; if (PRESS !== 1'b0) begin errors++; $display("FAIL rst_press: got %b expected 0", PRESS); end
        checks++; if (RELEASE !== 1'b0) begin errors++; $display("FAIL rst_release: got %b expected 0", RELEASE); end
        checks++; if (REPEAT !== 1'b0) begin errors++; $display("FAIL rst_repeat: got %b expected 0", REPEAT); end
        checks++; if (STROBE !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", STROBE); end
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_clean_press();
        REPEAT_EN = 1'b1;
        clr();
        for (int i = 1; i <= 25; i++) begin
            BT_N = (i <= 10) ? 1'b0 : 1'b1;
            tick();
            if (cyc == 10) begin
                checks++; if (LEVEL_N !== 1'b0) begin errors++; $display("FAIL clean_level_low: got %b expected 0", LEVEL_N); end
            end
        end
        checks++; if (np != 1) begin errors++; $display("FAIL clean_press_count: got %0d expected 1", np); end
        checks++; if (p_at != 6) begin errors++; $display("FAIL clean_press_cycle: got %0d expected 6", p_at); end
        checks++; if (nr != 1) begin errors++; $display("FAIL clean_release_count: got %0d expected 1", nr); end
        checks++; if (r_at != 16) begin errors++; $display("FAIL clean_release_cycle: got %0d expected 16", r_at); end
        checks++; if (rep_at.size() != 0) begin errors++; $display("FAIL clean_repeat_count: got %0d expected 0", rep_at.size()); end
        checks++; if (LEVEL_N !== 1'b1) begin errors++; $display("FAIL clean_level_high: got %b expected 1", LEVEL_N); end
        settle();
    endtask

    task automatic test_bounce();
        REPEAT_EN = 1'b0;
        clr();
        for (int i = 1; i <= 30; i++) begin
            BT_N = (i <= 12) ? (((i - 1) / 2) % 2 == 1) : 1'b0;
            tick();
        end
        checks++; if (np != 1) begin errors++; $display("FAIL bounce_press_count: got %0d expected 1", np); end
        checks++; if (p_at != 18) begin errors++; $display("FAIL bounce_press_cycle: got %0d expected 18", p_at); end
        checks++; if (nr != 0) begin errors++; $display("FAIL bounce_release_count: got %0d expected 0", nr); end
        checks++; if (LEVEL_N !== 1'b0) begin errors++; $display("FAIL bounce_level: got %b expected 0", LEVEL_N); end
        settle();
        checks++; if (LEVEL_N !== 1'b1) begin errors++; $display("FAIL bounce_level_after: got %b expected 1", LEVEL_N); end
    endtask

    task automatic test_hold_repeat();
        int got;
        REPEAT_EN = 1'b1;
        clr();
        for (int i = 1; i <= 80; i++) begin
            BT_N = (i <= 60) ? 1'b0 : 1'b1;
            tick();
        end
        checks++; if (rep_at.size() != 8) begin errors++; $display("FAIL hold_repeat_count: got %0d expected 8", rep_at.size()); end
        for (int j = 0; j < 8; j++) begin
            got = (j < rep_at.size()) ? rep_at[j] : -1;
            checks++; if (got != 26 + 5 * j) begin errors++; $display("FAIL hold_repeat_%0d: got cycle %0d expected %0d", j, got, 26 + 5 * j); end
        end
        checks++; if (nstb != 9) begin errors++; $display("FAIL hold_strobe_count: got %0d expected 9", nstb); end
        checks++; if (nboth != 0) begin errors++; $display("FAIL hold_press_and_repeat: got %0d expected 0", nboth); end
        checks++; if (r_at != 66) begin errors++; $display("FAIL hold_release_cycle: got %0d expected 66", r_at); end
        settle();
    endtask

    task automatic test_repeat_enable();
        int got;
        int e[5] = '{56, 61, 84, 89, 94};
        REPEAT_EN = 1'b0;
        clr();
        for (int i = 1; i <= 80; i++) begin
            BT_N = (i <= 60) ? 1'b0 : 1'b1;
            tick();
        end
        checks++; if (rep_at.size() != 0) begin errors++; $display("FAIL en_off_repeat_count: got %0d expected 0", rep_at.size()); end
        checks++; if (nr != 1) begin errors++; $display("FAIL en_off_release_count: got %0d expected 1", nr); end
        settle();
        REPEAT_EN = 1'b0;
        clr();
        for (int i = 1; i <= 110; i++) begin
            BT_N = (i <= 90) ? 1'b0 : 1'b1;
            tick();
            if (cyc == 36) REPEAT_EN = 1'b1;
            if (cyc == 62) REPEAT_EN = 1'b0;
            if (cyc == 64) REPEAT_EN = 1'b1;
        end
        checks++; if (p_at != 6) begin errors++; $display("FAIL en_press_cycle: got %0d expected 6", p_at); end
        checks++; if (rep_at.size() != 5) begin errors++; $display("FAIL en_repeat_count: got %0d expected 5", rep_at.size()); end
        for (int j = 0; j < 5; j++) begin
            got = (j < rep_at.size()) ? rep_at[j] : -1;
            checks++; if (got != e[j]) begin errors++; $display("FAIL en_repeat_%0d: got cycle %0d expected %0d", j, got, e[j]); end
        end
        checks++; if (r_at != 96) begin errors++; $display("FAIL en_release_cycle: got %0d expected 96", r_at); end
        settle();
    endtask

    task automatic test_release_boundary();
        REPEAT_EN = 1'b1;
        clr();
        for (int i = 1; i <= 60; i++) begin
            BT_N = (i <= 25) ? 1'b0 : 1'b1;
            tick();
            if (cyc == 31) begin
                checks++; if (RELEASE !== 1'b1) begin errors++; $display("FAIL boundary_release: got %b expected 1", RELEASE); end
                checks++; if (REPEAT !== 1'b0) begin errors++; $display("FAIL boundary_repeat: got %b expected 0", REPEAT); end
            end
        end
        checks++; if (rep_at.size() != 1) begin errors++; $display("FAIL boundary_repeat_count: got %0d expected 1", rep_at.size()); end
        checks++; if (nstb != 2) begin errors++; $display("FAIL boundary_strobe_count: got %0d expected 2", nstb); end
        checks++; if (nr != 1) begin errors++; $display("FAIL boundary_release_count: got %0d expected 1", nr); end
        settle();
    endtask

    task automatic test_reset_mid_hold();
        REPEAT_EN = 1'b1;
        BT_N = 1'b0;
        clr();
        for (int i = 1; i <= 28; i++) tick();
        checks++; if (LEVEL_N !== 1'b0) begin errors++; $display("FAIL midrst_level_before: got %b expected 0", LEVEL_N); end
        RST_N = 1'b0;
        #1;
        checks++; if (LEVEL_N !== 1'b1) begin errors++; $display("FAIL midrst_level: got %b expected 1", LEVEL_N); end
        checks++; if ({PRESS, RELEASE, REPEAT, STROBE} !== 4'b0000) begin errors++; $display("FAIL midrst_pulses: got %b expected 0000", {PRESS, RELEASE, REPEAT, STROBE}); end
        for (int i = 0; i < 3; i++) tick();
        RST_N = 1'b1;
        clr();
        for (int i = 1; i <= 15; i++) tick();
        checks++; if (np != 1) begin errors++; $display("FAIL midrst_press_count: got %0d expected 1", np); end
        checks++; if (p_at != 6) begin errors++; $display("FAIL midrst_press_cycle: got %0d expected 6", p_at); end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_repeat_enable();
        test_release_boundary();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
